pipeline_wb_stage: RTL and testbench
====================================

PIPELINE_WB_STAGE -- requirements
Module: pipeline_wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `reset`, both sampled on the `clk` rising edge.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- valid_MEM  in  1  MEM stage holds a valid instruction
- stall_WB  in  1  hold the WB register contents
- flush_WB  in  1  load a bubble into the WB register
- pc_MEM  in  64  instruction PC
- alu_result_MEM  in  64  ALU result; bits [2:0] give the load byte offset
- dm_rdata_MEM  in  64  aligned doubleword read from data memory
- rd_MEM  in  5  destination register
- rf_wr_en_MEM  in  1  instruction writes a register
- rf_wr_sel_MEM  in  2  write-back source select
- dm_rd_ctrl_MEM  in  3  load type
- reg_write_enable_WB  out  1  register-file write enable
- reg_write_addr_WB  out  5  register-file write address
- reg_write_data_WB  out  64  register-file write data
- valid_WB  out  1  WB stage holds a valid instruction
- load_misalign_WB  out  1  misaligned load detected in WB
- instret  out  64  retired-instruction counter

Function
REQ-003 The WB register SHALL capture all *_MEM inputs on each rising edge, giving 1-cycle latency from MEM to the WB outputs.
REQ-004 Register update priority SHALL be reset > flush_WB > stall_WB > normal capture.
REQ-005 flush_WB SHALL clear the registered valid bit; the other registered fields are don't-care.
REQ-006 stall_WB SHALL hold every registered field, including valid, unchanged.
REQ-007 rf_wr_sel encoding SHALL be:
- 00: data = 0
- 01: data = pc + 4, 64-bit wrap
- 10: data = ALU result
- 11: data = extracted load data
REQ-008 dm_rd_ctrl encoding SHALL be: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWU, 111 LD.
REQ-009 Load extraction SHALL select the byte lane at offset = alu_result[2:0] (little-endian), then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to 64 bits; LD SHALL pass all 64 bits through.
REQ-010 A load SHALL be flagged misaligned when it is a halfword with offset[0]≠0, a word with offset[1:0]≠0, or LD with offset≠0; the flag SHALL be gated by valid.
REQ-011 load_misalign_WB SHALL be combinational from the registered fields.
REQ-012 reg_write_enable_WB SHALL equal valid & rf_wr_en & (rd≠0) & !load_misalign_WB.
REQ-013 reg_write_addr_WB and reg_write_data_WB SHALL be combinational from the registered fields and SHALL drive 0 whenever reg_write_enable_WB=0.
REQ-014 During stall_WB the write SHALL be re-presented each cycle; repeated writes are permitted and idempotent.
REQ-015 instret SHALL increment by 1 on a rising edge where valid_WB=1, stall_WB=0 and load_misalign_WB=0.
REQ-016 instret SHALL wrap from 2^64-1 to 0.
REQ-017 flush_WB SHALL NOT cancel the increment for the instruction currently in WB.

Reset
REQ-018 On reset the valid bit, all registered fields and instret SHALL be cleared, so every output reads 0 from the following cycle.
REQ-019 Reset asserted mid-stall SHALL discard the held instruction with no write and no instret increment on that edge.

Verification
REQ-020 ALU op: rd=5, rf_wr_en=1, sel=10, alu=0x1234, valid=1 -> next cycle en=1, addr=5, data=0x1234; instret +1.
REQ-021 LB: rdata=0x00000000_00800000, alu=0x1002, ctrl=001, sel=11 -> data=0xFFFFFFFF_FFFFFF80.
- Same stimulus with LBU -> data=0x80.
REQ-022 Misaligned LW: alu=0x1006, ctrl=101 -> load_misalign_WB=1, en=0, addr=0, data=0; instret unchanged.
REQ-023 JAL write-back: pc=0xFFFFFFFF_FFFFFFFC, sel=01, rd=1 -> data=0.
- rd=0 with the same stimulus -> en=0.
REQ-024 Stall then flush:
- stall_WB held 3 cycles -> identical outputs all 3 cycles, instret unchanged.
- Release stall with flush_WB=1 -> instret +1 once, valid_WB=0 next cycle.
REQ-025 Counter wrap and reset: preload instret=2^64-1, retire one instruction -> instret=0; then assert reset -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pipeline_wb_stage.sv
// Write-back stage: registers the MEM-stage results, extracts and extends load data,
// selects the register-file write value and counts retired instructions.
module pipeline_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_MEM,
  input  logic        stall_WB,
  input  logic        flush_WB,
  input  logic [63:0] pc_MEM,
  input  logic [63:0] alu_result_MEM,
  input  logic [63:0] dm_rdata_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic        rf_wr_en_MEM,
  input  logic [1:0]  rf_wr_sel_MEM,
  input  logic [2:0]  dm_rd_ctrl_MEM,
  output logic        reg_write_enable_WB,
  output logic [4:0]  reg_write_addr_WB,
  output logic [63:0] reg_write_data_WB,
  output logic        valid_WB,
  output logic        load_misalign_WB,
  output logic [63:0] instret
);

  logic        r_valid;
  logic [63:0] r_pc;
  logic [63:0] r_alu;
  logic [63:0] r_rdata;
  logic [4:0]  r_rd;
  logic        r_wr_en;
  logic [1:0]  r_sel;
  logic [2:0]  r_ctrl;
  logic [63:0] r_instret;

  logic [2:0]  w_off;
  logic [63:0] w_lane;
  logic [63:0] w_load;
  logic [63:0] w_wb_data;
  logic        w_misalign;
  logic        w_we;

  // WB pipeline register; a flush only kills valid, the payload is don't-care and held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= 64'd0;
      r_alu   <= 64'd0;
      r_rdata <= 64'd0;
      r_rd    <= 5'd0;
      r_wr_en <= 1'b0;
      r_sel   <= 2'b00;
      r_ctrl  <= 3'b000;
    end else if (flush_WB) begin
      r_valid <= 1'b0;
    end else if (stall_WB) begin
      r_valid <= r_valid;
    end else begin
      r_valid <= valid_MEM;
      r_pc    <= pc_MEM;
      r_alu   <= alu_result_MEM;
      r_rdata <= dm_rdata_MEM;
      r_rd    <= rd_MEM;
      r_wr_en <= rf_wr_en_MEM;
      r_sel   <= rf_wr_sel_MEM;
      r_ctrl  <= dm_rd_ctrl_MEM;
    end
  end

  // Retirement counter; the instruction leaving WB counts even when a flush loads a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= 64'd0;
    end else if (r_valid && !stall_WB && !w_misalign) begin
      r_instret <= r_instret + 64'd1;
    end else begin
      r_instret <= r_instret;
    end
  end

  assign w_off  = r_alu[2:0];
  assign w_lane = r_rdata >> {w_off, 3'b000};

  // Load-type extension of the little-endian lane starting at the byte offset
  always_comb begin
    w_load = 64'd0;
    case (r_ctrl)
      3'b001:  w_load = {{56{w_lane[7]}}, w_lane[7:0]};
      3'b010:  w_load = {56'd0, w_lane[7:0]};
      3'b011:  w_load = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {48'd0, w_lane[15:0]};
      3'b101:  w_load = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b110:  w_load = {32'd0, w_lane[31:0]};
      3'b111:  w_load = r_rdata;
      default: w_load = 64'd0;
    endcase
  end

  // Alignment check by access size, only meaningful for a valid instruction
  always_comb begin
    w_misalign = 1'b0;
    if (r_valid) begin
      case (r_ctrl)
        3'b011, 3'b100: w_misalign = w_off[0];
        3'b101, 3'b110: w_misalign = |w_off[1:0];
        3'b111:         w_misalign = |w_off;
        default:        w_misalign = 1'b0;
      endcase
    end else begin
      w_misalign = 1'b0;
    end
  end

  // Write-back source select; link address wraps naturally at 64 bits
  always_comb begin
    w_wb_data = 64'd0;
    case (r_sel)
      2'b00:   w_wb_data = 64'd0;
      2'b01:   w_wb_data = r_pc + 64'd4;
      2'b10:   w_wb_data = r_alu;
      2'b11:   w_wb_data = w_load;
      default: w_wb_data = 64'd0;
    endcase
  end

  assign w_we = r_valid & r_wr_en & (r_rd != 5'd0) & ~w_misalign;

  assign reg_write_enable_WB = w_we;
  assign reg_write_addr_WB   = w_we ? r_rd : 5'd0;
  assign reg_write_data_WB   = w_we ? w_wb_data : 64'd0;
  assign valid_WB            = r_valid;
  assign load_misalign_WB    = w_misalign;
  assign instret             = r_instret;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Directed-vector bench for pipeline_wb_stage with hand-computed expectations.
module tb_pipeline_wb_stage;

  logic        clk;
  logic        reset;
  logic        valid_MEM;
  logic        stall_WB;
  logic        flush_WB;
  logic [63:0] pc_MEM;
  logic [63:0] alu_result_MEM;
  logic [63:0] dm_rdata_MEM;
  logic [4:0]  rd_MEM;
  logic        rf_wr_en_MEM;
  logic [1:0]  rf_wr_sel_MEM;
  logic [2:0]  dm_rd_ctrl_MEM;
  logic        reg_write_enable_WB;
  logic [4:0]  reg_write_addr_WB;
  logic [63:0] reg_write_data_WB;
  logic        valid_WB;
  logic        load_misalign_WB;
  logic [63:0] instret;

  int n_cmp;
  int n_err;

  pipeline_wb_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .valid_MEM           (valid_MEM),
    .stall_WB            (stall_WB),
    .flush_WB            (flush_WB),
    .pc_MEM              (pc_MEM),
    .alu_result_MEM      (alu_result_MEM),
    .dm_rdata_MEM        (dm_rdata_MEM),
    .rd_MEM              (rd_MEM),
    .rf_wr_en_MEM        (rf_wr_en_MEM),
    .rf_wr_sel_MEM       (rf_wr_sel_MEM),
    .dm_rd_ctrl_MEM      (dm_rd_ctrl_MEM),
    .reg_write_enable_WB (reg_write_enable_WB),
    .reg_write_addr_WB   (reg_write_addr_WB),
    .reg_write_data_WB   (reg_write_data_WB),
    .valid_WB            (valid_WB),
    .load_misalign_WB    (load_misalign_WB),
    .instret             (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [4:0] addr,
                          input logic [63:0] data, input logic vld, input logic mis,
                          input logic [63:0] cnt);
    chk({tag, ".en"},   {63'd0, reg_write_enable_WB}, {63'd0, en});
    chk({tag, ".addr"}, {59'd0, reg_write_addr_WB},   {59'd0, addr});
    chk({tag, ".data"}, reg_write_data_WB,            data);
    chk({tag, ".vld"},  {63'd0, valid_WB},            {63'd0, vld});
    chk({tag, ".mis"},  {63'd0, load_misalign_WB},    {63'd0, mis});
    chk({tag, ".cnt"},  instret,                      cnt);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] alu,
                       input logic [63:0] rdata, input logic [4:0] rd, input logic wen,
                       input logic [1:0] sel, input logic [2:0] ctrl);
    valid_MEM      = v;
    pc_MEM         = pc;
    alu_result_MEM = alu;
    dm_rdata_MEM   = rdata;
    rd_MEM         = rd;
    rf_wr_en_MEM   = wen;
    rf_wr_sel_MEM  = sel;
    dm_rd_ctrl_MEM = ctrl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] RD8 = 64'h8877_6655_4433_2211;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    stall_WB = 1'b0;
    flush_WB = 1'b0;
    drive(1'b1, 64'h100, 64'h55, 64'h66, 5'd3, 1'b1, 2'b10, 3'b000);
    step();
    step();
    check_wb("reset", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 64'd0);
    reset = 1'b0;

    drive(1'b1, 64'h100, 64'h1234, 64'd0, 5'd5, 1'b1, 2'b10, 3'b000);
    step();
    check_wb("alu", 1'b1, 5'd5, 64'h1234, 1'b1, 1'b0, 64'd0);

    drive(1'b1, 64'h104, 64'h1002, 64'h0000_0000_0080_0000, 5'd7, 1'b1, 2'b11, 3'b001);
    step();
    check_wb("lb", 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 64'd1);

    drive(1'b1, 64'h108, 64'h1002, 64'h0000_0000_0080_0000, 5'd7, 1'b1, 2'b11, 3'b010);
    step();
    check_wb("lbu", 1'b1, 5'd7, 64'h80, 1'b1, 1'b0, 64'd2);

    drive(1'b1, 64'h10C, 64'h1006, RD8, 5'd8, 1'b1, 2'b11, 3'b101);
    step();
    check_wb("lw_mis", 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 64'd3);

    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 5'd1, 1'b1, 2'b01, 3'b000);
    step();
    check_wb("jal", 1'b1, 5'd1, 64'd0, 1'b1, 1'b0, 64'd3);

    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 5'd0, 1'b1, 2'b01, 3'b000);
    step();
    check_wb("jal_x0", 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 64'd4);

    drive(1'b1, 64'h110, 64'h2004, RD8, 5'd3, 1'b1, 2'b11, 3'b101);
    step();
    check_wb("lw4", 1'b1, 5'd3, 64'hFFFF_FFFF_8877_6655, 1'b1, 1'b0, 64'd5);

    drive(1'b1, 64'h114, 64'h2006, RD8, 5'd3, 1'b1, 2'b11, 3'b011);
    step();
    check_wb("lh6", 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_8877, 1'b1, 1'b0, 64'd6);

    drive(1'b1, 64'h118, 64'h2000, RD8, 5'd3, 1'b1, 2'b11, 3'b111);
    step();
    check_wb("ld", 1'b1, 5'd3, RD8, 1'b1, 1'b0, 64'd7);

    drive(1'b1, 64'h11C, 64'h9999, RD8, 5'd3, 1'b1, 2'b00, 3'b000);
    step();
    check_wb("sel0", 1'b1, 5'd3, 64'd0, 1'b1, 1'b0, 64'd8);

    drive(1'b1, 64'h120, 64'hABCD, 64'd0, 5'd9, 1'b1, 2'b10, 3'b000);
    step();
    check_wb("pre_stall", 1'b1, 5'd9, 64'hABCD, 1'b1, 1'b0, 64'd9);

    stall_WB = 1'b1;
    drive(1'b1, 64'h124, 64'h5555, 64'd0, 5'd10, 1'b1, 2'b10, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_wb($sformatf("stall%0d", i), 1'b1, 5'd9, 64'hABCD, 1'b1, 1'b0, 64'd9);
    end

    stall_WB = 1'b0;
    flush_WB = 1'b1;
    step();
    check_wb("flush", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 64'd10);

    flush_WB = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'b00, 3'b000);
    step();
    check_wb("bubble", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 64'd10);

    drive(1'b1, 64'h130, 64'h1, 64'd0, 5'd2, 1'b1, 2'b10, 3'b000);
    step();
    check_wb("pre_wrap", 1'b1, 5'd2, 64'h1, 1'b1, 1'b0, 64'd10);
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    #1;
    chk("preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);

    drive(1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'b00, 3'b000);
    step();
    check_wb("wrap", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 64'd0);

    drive(1'b1, 64'h140, 64'h77, 64'd0, 5'd4, 1'b1, 2'b10, 3'b000);
    step();
    check_wb("pre_rst", 1'b1, 5'd4, 64'h77, 1'b1, 1'b0, 64'd0);
    stall_WB = 1'b1;
    step();
    check_wb("stall_rst", 1'b1, 5'd4, 64'h77, 1'b1, 1'b0, 64'd0);
    reset = 1'b1;
    step();
    check_wb("rst_mid_stall", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 64'd0);
    reset    = 1'b0;
    stall_WB = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
